// File: rtl/conf_int_mac__apx_pipe__w_wrapper.sv
// Signed MAC: TAPS operand pairs -> one shifted, saturated dot-product result, with optional LSB-truncating approx mode.
// Latency: result valid 3 edges after the last beat is accepted; operand reg -> product reg -> accumulator.
// Backpressure: input stalls (in_ready=0) from the last beat until the held result is taken via out_ready.
module conf_int_mac__apx_pipe__w_wrapper #(
    parameter int DATA_PATH_BITWIDTH = 24,
    parameter int APX_BITS           = 8,
    parameter int TAPS               = 8,
    parameter int OUT_BITWIDTH       = 32,
    parameter int OUT_SHIFT          = 8
) (
    input  logic                          clk,
    input  logic                          racc,
    input  logic                          rstP,
    input  logic                          rapx,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_BITWIDTH-1:0]       p,
    output logic                          sat,
    output logic                          busy
);
    localparam int W     = DATA_PATH_BITWIDTH;
    localparam int CNT_W = $clog2(TAPS);
    localparam int ACC_W = 2*W + $clog2(TAPS);

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS-1);
    localparam logic [W-1:0]     APX_MASK = {W{1'b1}} << APX_BITS;

    localparam logic signed [ACC_W-1:0] P_MAX =
        {{(ACC_W-OUT_BITWIDTH+1){1'b0}}, {(OUT_BITWIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] P_MIN =
        {{(ACC_W-OUT_BITWIDTH+1){1'b1}}, {(OUT_BITWIDTH-1){1'b0}}};

    logic [1:0]               state;
    logic [CNT_W-1:0]         tap_cnt;
    logic                     apx_q;
    logic                     op_vld;
    logic signed [W-1:0]      op_a;
    logic signed [W-1:0]      op_b;
    logic                     prod_vld;
    logic signed [2*W-1:0]    prod;
    logic signed [ACC_W-1:0]  acc;

    logic                     accept;
    logic                     cur_apx;
    logic [W-1:0]             op_mask;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  r;
    logic [OUT_BITWIDTH-1:0]  p_nxt;
    logic                     sat_nxt;

    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_HOLD);
    assign busy      = (tap_cnt != '0) || (state != ST_ACCUM);
    assign accept    = in_valid && in_ready;

    // Mode is taken live on the first beat, then from the latched copy for the rest of the group.
    assign cur_apx  = (tap_cnt == '0) ? rapx : apx_q;
    assign op_mask  = cur_apx ? APX_MASK : {W{1'b1}};
    assign prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
    assign r        = acc >>> OUT_SHIFT;

    always_comb begin
        p_nxt   = r[OUT_BITWIDTH-1:0];
        sat_nxt = 1'b0;
        if (r > P_MAX) begin
            p_nxt   = P_MAX[OUT_BITWIDTH-1:0];
            sat_nxt = 1'b1;
        end else if (r < P_MIN) begin
            p_nxt   = P_MIN[OUT_BITWIDTH-1:0];
            sat_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge racc) begin
        if (racc) begin
            state    <= ST_ACCUM;
            tap_cnt  <= '0;
            apx_q    <= 1'b0;
            op_vld   <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            prod_vld <= 1'b0;
            prod     <= '0;
            acc      <= '0;
            p        <= '0;
            sat      <= 1'b0;
        end else if (rstP) begin
            state    <= ST_ACCUM;
            tap_cnt  <= '0;
            apx_q    <= 1'b0;
            op_vld   <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            prod_vld <= 1'b0;
            prod     <= '0;
            acc      <= '0;
            p        <= '0;
            sat      <= 1'b0;
        end else begin
            op_vld   <= accept;
            prod_vld <= op_vld;
            if (accept) begin
                op_a <= a & op_mask;
                op_b <= b & op_mask;
                if (tap_cnt == '0) begin
                    apx_q <= rapx;
                end
            end
            if (op_vld) begin
                prod <= op_a * op_b;
            end
            if (state == ST_HOLD && out_ready) begin
                acc <= '0;
            end else if (prod_vld) begin
                acc <= acc + prod_ext;
            end

            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        if (tap_cnt == LAST_TAP) begin
                            tap_cnt <= '0;
                            state   <= ST_FLUSH;
                        end else begin
                            tap_cnt <= tap_cnt + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Both pipeline stages empty means the last product is already in acc.
                    if (!op_vld && !prod_vld) begin
                        p     <= p_nxt;
                        sat   <= sat_nxt;
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state <= ST_ACCUM;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end
endmodule
